// File: rtl/alu_pkg.sv
// Shared constants for the add/sub/compare datapath and its arbiter.
package alu_pkg;

  localparam int unsigned XLEN_DEF = 64;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_SLT  = 2'b10;
  localparam logic [1:0] OP_SLTU = 2'b11;

endpackage

// File: rtl/alu_cmp_core.sv
// Combinational add/sub/compare core built around a single adder chain.
module alu_cmp_core
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF
) (
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN-1:0] res_data_c,
  output logic            res_cout_c
);

  logic            sub_c;
  logic [XLEN-1:0] b_eff_c;
  logic [XLEN-1:0] sum_c;
  logic            carry_c;
  logic            slt_c;

  // Everything except ADD subtracts; compares reuse the subtract result.
  always_comb begin
    sub_c              = (op_i != OP_ADD);
    b_eff_c            = sub_c ? ~b_i : b_i;
    {carry_c, sum_c}   = {1'b0, a_i} + {1'b0, b_eff_c} + (XLEN+1)'(sub_c);
    slt_c              = (a_i[XLEN-1] & ~b_i[XLEN-1]) |
                         (~(a_i[XLEN-1] ^ b_i[XLEN-1]) & sum_c[XLEN-1]);
    res_data_c         = sum_c;
    res_cout_c         = carry_c;
    case (op_i)
      OP_SLT: begin
        res_data_c = {{(XLEN-1){1'b0}}, slt_c};
        res_cout_c = 1'b0;
      end
      OP_SLTU: begin
        res_data_c = {{(XLEN-1){1'b0}}, ~carry_c};
        res_cout_c = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter sharing one add/sub/compare core across NREQ requesters,
// with a single registered, id-tagged response channel.
module alu_rr_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF,
  parameter int unsigned NREQ = 2,
  parameter int unsigned IDW  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [2*NREQ-1:0]    req_op,
  input  logic [XLEN*NREQ-1:0] req_a,
  input  logic [XLEN*NREQ-1:0] req_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [XLEN-1:0]      rsp_data,
  output logic                 rsp_cout
);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [XLEN-1:0] data_q, data_d;
  logic            cout_q, cout_d;

  logic [IDW-1:0]  gnt_c;
  logic            gnt_vld_c;
  logic            can_accept_c;
  logic            accept_c;
  logic [1:0]      sel_op_c;
  logic [XLEN-1:0] sel_a_c;
  logic [XLEN-1:0] sel_b_c;
  logic [XLEN-1:0] core_data_c;
  logic            core_cout_c;

  // First valid requester at or after ptr, wrapping at NREQ.
  always_comb begin
    int unsigned idx;
    idx       = 0;
    gnt_c     = '0;
    gnt_vld_c = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = 32'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (!gnt_vld_c && (i == idx) && req_valid[i]) begin
          gnt_vld_c = 1'b1;
          gnt_c     = IDW'(i);
        end
      end
    end
  end

  // Handshake: a response slot is free when empty or being drained this cycle.
  always_comb begin
    can_accept_c = (state_q == ST_EMPTY) | rsp_ready;
    accept_c     = gnt_vld_c & can_accept_c & rst_n;
    req_ready    = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (accept_c && (IDW'(i) == gnt_c)) req_ready[i] = 1'b1;
    end
  end

  // Route the granted requester's op and operands into the core.
  always_comb begin
    sel_op_c = '0;
    sel_a_c  = '0;
    sel_b_c  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (IDW'(i) == gnt_c) begin
        sel_op_c = req_op[2*i +: 2];
        sel_a_c  = req_a[XLEN*i +: XLEN];
        sel_b_c  = req_b[XLEN*i +: XLEN];
      end
    end
  end

  alu_cmp_core #(
    .XLEN(XLEN)
  ) u_core (
    .op_i       (sel_op_c),
    .a_i        (sel_a_c),
    .b_i        (sel_b_c),
    .res_data_c (core_data_c),
    .res_cout_c (core_cout_c)
  );

  // Next-state: capture on accept, drain when consumed, otherwise hold.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    data_d  = data_q;
    cout_d  = cout_q;
    if (accept_c) begin
      state_d = ST_FULL;
      id_d    = gnt_c;
      data_d  = core_data_c;
      cout_d  = core_cout_c;
      ptr_d   = (gnt_c == IDW'(NREQ-1)) ? '0 : gnt_c + IDW'(1);
    end else if ((state_q == ST_FULL) && rsp_ready) begin
      state_d = ST_EMPTY;
    end
  end

  // State and response registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      ptr_q   <= '0;
      id_q    <= '0;
      data_q  <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      data_q  <= data_d;
      cout_q  <= cout_d;
    end
  end

  assign rsp_valid = (state_q == ST_FULL);
  assign rsp_id    = id_q;
  assign rsp_data  = data_q;
  assign rsp_cout  = cout_q;

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Self-checking bench for alu_rr_arbiter: directed cases plus randomized
// traffic compared every cycle against a behavioural model.
module tb_alu_rr_arbiter;
  import alu_pkg::*;

  localparam int XLEN = 64;
  localparam int NREQ = 2;
  localparam int IDW  = 2;

  logic                 clk;
  logic                 rst_n;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [2*NREQ-1:0]    req_op;
  logic [XLEN*NREQ-1:0] req_a;
  logic [XLEN*NREQ-1:0] req_b;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [IDW-1:0]       rsp_id;
  logic [XLEN-1:0]      rsp_data;
  logic                 rsp_cout;

  int errors = 0;
  int checks = 0;

  alu_rr_arbiter #(.XLEN(XLEN), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_cout  (rsp_cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference arithmetic straight from the operation definitions.
  function automatic void alu_model(input logic [1:0] op, input logic [63:0] a,
                                    input logic [63:0] b, output logic [63:0] d,
                                    output logic c);
    logic [64:0] t;
    t = '0;
    d = '0;
    c = 1'b0;
    case (op)
      2'b00: begin t = {1'b0, a} + {1'b0, b};          d = t[63:0]; c = t[64]; end
      2'b01: begin t = {1'b0, a} + {1'b0, ~b} + 65'd1; d = t[63:0]; c = t[64]; end
      2'b10: d = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
      default: d = (a < b) ? 64'd1 : 64'd0;
    endcase
  endfunction

  // Behavioural model state.
  int          m_ptr = 0;
  logic        m_valid = 1'b0;
  logic [1:0]  m_id = '0;
  logic [63:0] m_data = '0;
  logic        m_cout = 1'b0;
  logic        p_acc = 1'b0;
  logic        p_drain = 1'b0;
  int          p_g = 0;
  logic [1:0]  p_op = '0;
  logic [63:0] p_a = '0;
  logic [63:0] p_b = '0;

  // Model update on the rising edge, comparison on the falling edge.
  always begin
    int          g;
    int          idx;
    logic        can;
    logic [1:0]  exp_rdy;
    logic [63:0] d;
    logic        c;
    @(posedge clk);
    if (!rst_n) begin
      m_valid = 1'b0; m_id = '0; m_data = '0; m_cout = 1'b0; m_ptr = 0;
    end else if (p_acc) begin
      alu_model(p_op, p_a, p_b, d, c);
      m_valid = 1'b1; m_id = 2'(p_g); m_data = d; m_cout = c;
      m_ptr = (p_g + 1) % NREQ;
    end else if (p_drain) begin
      m_valid = 1'b0;
    end
    @(negedge clk);
    g = -1;
    for (int k = 0; k < NREQ; k++) begin
      idx = (m_ptr + k) % NREQ;
      if (g < 0 && req_valid[idx]) g = idx;
    end
    can     = !m_valid || rsp_ready;
    exp_rdy = '0;
    p_acc   = 1'b0;
    p_drain = 1'b0;
    if (rst_n && g >= 0 && can) begin
      exp_rdy[g] = 1'b1;
      p_acc = 1'b1;
      p_g   = g;
      p_op  = req_op[2*g +: 2];
      p_a   = req_a[XLEN*g +: XLEN];
      p_b   = req_b[XLEN*g +: XLEN];
    end else if (rst_n && m_valid && rsp_ready) begin
      p_drain = 1'b1;
    end
    check("model_req_ready", 64'(req_ready), 64'(exp_rdy));
    check("model_rsp_valid", 64'(rsp_valid), 64'(m_valid));
    check("model_rsp_id",    64'(rsp_id),    64'(m_id));
    check("model_rsp_data",  rsp_data,       m_data);
    check("model_rsp_cout",  64'(rsp_cout),  64'(m_cout));
  end

  function automatic logic [63:0] rnd_val();
    case ($urandom_range(0, 5))
      0: return 64'd0;
      1: return 64'd1;
      2: return 64'hFFFF_FFFF_FFFF_FFFF;
      3: return 64'h8000_0000_0000_0000;
      4: return 64'h7FFF_FFFF_FFFF_FFFF;
      default: return {$urandom(), $urandom()};
    endcase
  endfunction

  // Single request on req0, literal expectations on handshake and result.
  task automatic run_one(input string name, input logic [1:0] op, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] ed, input logic ec);
    cyc();
    req_valid = 2'b01;
    req_op[1:0] = op;
    req_a[63:0] = a;
    req_b[63:0] = b;
    @(negedge clk);
    check({name, "_ready"}, 64'(req_ready), 64'd1);
    cyc();
    req_valid = 2'b00;
    @(negedge clk);
    check({name, "_valid"}, 64'(rsp_valid), 64'd1);
    check({name, "_id"},    64'(rsp_id),    64'd0);
    check({name, "_data"},  rsp_data,       ed);
    check({name, "_cout"},  64'(rsp_cout),  64'(ec));
  endtask

  initial begin
    logic [63:0] held;
    logic [1:0]  vld_prev, rdy_prev;
    rst_n = 1'b0; req_valid = '0; req_op = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
    repeat (3) cyc();
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_valid", 64'(rsp_valid), 64'd0);
    check("reset_data",  rsp_data,       64'd0);

    run_one("add_5_7",  OP_ADD,  64'd5, 64'd7, 64'd12, 1'b0);
    run_one("sub_0_1",  OP_SUB,  64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    run_one("sub_1_1",  OP_SUB,  64'd1, 64'd1, 64'd0, 1'b1);
    run_one("slt_m1_1", OP_SLT,  64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd1, 1'b0);
    run_one("sltu_m1_1", OP_SLTU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b0);
    run_one("slt_min_max", OP_SLT, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
    run_one("sltu_min_max", OP_SLTU, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 1'b0);
    run_one("slt_eq", OP_SLT, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0);
    run_one("sltu_eq", OP_SLTU, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0);

    // Both requesting continuously: grants alternate with no bubbles.
    cyc(); rst_n = 1'b0;
    cyc(); rst_n = 1'b1;
    req_valid = 2'b11;
    req_op = 4'($urandom()); req_a = {$urandom(), $urandom(), $urandom(), $urandom()};
    req_b = {$urandom(), $urandom(), $urandom(), $urandom()};
    @(negedge clk);
    check("alt_first_grant", 64'(req_ready), 64'd1);
    for (int k = 1; k <= 6; k++) begin
      cyc();
      req_op = 4'($urandom()); req_a = {$urandom(), $urandom(), $urandom(), $urandom()};
      req_b = {$urandom(), $urandom(), $urandom(), $urandom()};
      @(negedge clk);
      check("alt_rsp_valid", 64'(rsp_valid), 64'd1);
      check("alt_rsp_id",    64'(rsp_id),    64'((k - 1) % 2));
      check("alt_grant",     64'(req_ready), (k % 2 == 1) ? 64'd2 : 64'd1);
    end

    // Backpressure for three cycles, then release to the pending winner.
    cyc(); rsp_ready = 1'b0;
    @(negedge clk);
    held = rsp_data;
    check("bp_ready", 64'(req_ready), 64'd0);
    check("bp_id",    64'(rsp_id),    64'd0);
    repeat (2) begin
      cyc();
      @(negedge clk);
      check("bp_ready", 64'(req_ready), 64'd0);
      check("bp_valid", 64'(rsp_valid), 64'd1);
      check("bp_data",  rsp_data,       held);
    end
    cyc(); rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_release_winner", 64'(req_ready), 64'd2);

    // Reset while FULL with both requesting.
    cyc(); rst_n = 1'b0;
    @(negedge clk);
    check("rst_ready", 64'(req_ready), 64'd0);
    cyc();
    @(negedge clk);
    check("rst_valid", 64'(rsp_valid), 64'd0);
    check("rst_ready2", 64'(req_ready), 64'd0);
    cyc(); rst_n = 1'b1;
    @(negedge clk);
    check("rst_first_grant", 64'(req_ready), 64'd1);

    // Randomized traffic with backpressure, drops and occasional reset.
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      vld_prev = req_valid;
      rdy_prev = req_ready;
      cyc();
      rst_n     = ($urandom_range(0, 199) != 0);
      rsp_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NREQ; i++) begin
        if (vld_prev[i] && !rdy_prev[i]) begin
          req_valid[i] = ($urandom_range(0, 9) != 0);
        end else begin
          req_valid[i] = ($urandom_range(0, 9) < 6);
          req_op[2*i +: 2] = 2'($urandom());
          req_a[XLEN*i +: XLEN] = rnd_val();
          req_b[XLEN*i +: XLEN] = rnd_val();
        end
      end
    end

    cyc(); req_valid = '0;
    repeat (2) cyc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
